// File: rtl/icache_tag_pkg.sv
// Shared opcodes, request/result records and victim selection for the icache tag lookup.
package icache_tag_pkg;

  localparam int unsigned WAYS = 2;

  localparam logic [6:0] OPC_READ     = 7'h01;
  localparam logic [6:0] OPC_PREFETCH = 7'h02;
  localparam logic [6:0] OPC_SNP_INV  = 7'h10;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [3:0]  txnid;
    logic [31:0] addr;
  } tag_req_t;

  typedef struct packed {
    tag_req_t req;
    logic     hit;
    logic     way;
  } tag_res_t;

  function automatic logic pick_victim(input logic [WAYS-1:0] valid, input logic lru);
    if (!valid[0]) return 1'b0;
    if (!valid[1]) return 1'b1;
    return lru;
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Flop-based 2-way tag/valid/lru storage: one combinational read port, lookup-update and fill write ports.
module icache_tag_array
  import icache_tag_pkg::*;
#(
  parameter int unsigned SETS    = 64,
  parameter int unsigned TAG_W   = 20,
  parameter int unsigned INDEX_W = $clog2(SETS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [INDEX_W-1:0]           rd_index,
  output logic [WAYS-1:0]              rd_valid,
  output logic [WAYS-1:0][TAG_W-1:0]   rd_tag,
  output logic                         rd_lru,
  input  logic                         upd_en,
  input  logic [INDEX_W-1:0]           upd_index,
  input  logic                         upd_way,
  input  logic                         upd_inv,
  input  logic                         upd_lru,
  input  logic                         fill_en,
  input  logic [INDEX_W-1:0]           fill_index,
  input  logic                         fill_way,
  input  logic [TAG_W-1:0]             fill_tag
);

  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [SETS-1:0]            lru_q;
  logic [WAYS-1:0][TAG_W-1:0] tag_q [SETS];

  // Fill is written last so it overrides a same-set lookup update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      if (upd_en) begin
        if (upd_inv) valid_q[upd_index][upd_way] <= 1'b0;
        lru_q[upd_index] <= upd_lru;
      end
      if (fill_en) begin
        valid_q[fill_index][fill_way] <= 1'b1;
        lru_q[fill_index]             <= ~fill_way;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) tag_q[fill_index][fill_way] <= fill_tag;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_lru   = lru_q[rd_index];

endmodule

// File: rtl/icache_tag_lookup.sv
// Two-stage icache tag lookup (S1 request register + result register) over a 2-way tag array.
// Optional ICACHE_TAG_FILL_BYPASS_EN forwards a same-cycle fill into the S1 compare.
module icache_tag_lookup
  import icache_tag_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned TXNID_WIDTH  = 4,
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned SETS         = 64,
  parameter int unsigned LINE_BYTES   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tag_req_vld,
  output logic                    tag_req_rdy,
  input  logic [OPCODE_WIDTH-1:0] tag_req_opcode,
  input  logic [TXNID_WIDTH-1:0]  tag_req_txnid,
  input  logic [ADDR_WIDTH-1:0]   tag_req_addr,
  input  logic                    fill_vld,
  input  logic [ADDR_WIDTH-1:0]   fill_addr,
  input  logic                    fill_way,
  output logic                    res_vld,
  input  logic                    res_rdy,
  output logic [OPCODE_WIDTH-1:0] res_opcode,
  output logic [TXNID_WIDTH-1:0]  res_txnid,
  output logic [ADDR_WIDTH-1:0]   res_addr,
  output logic                    res_hit,
  output logic                    res_way
);

  localparam int unsigned INDEX_W  = $clog2(SETS);
  localparam int unsigned OFFSET_W = $clog2(LINE_BYTES);
  localparam int unsigned TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;

  logic                       s1_vld;
  tag_req_t                   s1_req;
  logic                       res_vld_q;
  tag_res_t                   res_q;
  logic                       accept, s1_adv;
  logic [INDEX_W-1:0]         s1_index, fill_index;
  logic [TAG_W-1:0]           s1_tag, fill_tag;
  logic [WAYS-1:0]            arr_valid, eff_valid, way_match;
  logic [WAYS-1:0][TAG_W-1:0] arr_tag, eff_tag;
  logic                       arr_lru;
  logic                       hit, hit_way, victim;
  logic                       upd_en, upd_inv, upd_lru;
  logic                       unused_fill_offset;

  assign tag_req_rdy = !reset && (!s1_vld || !res_vld_q || res_rdy);
  assign accept      = tag_req_vld && tag_req_rdy;
  assign s1_adv      = s1_vld && (!res_vld_q || res_rdy);

  assign s1_index   = s1_req.addr[OFFSET_W +: INDEX_W];
  assign s1_tag     = s1_req.addr[ADDR_WIDTH-1 -: TAG_W];
  assign fill_index = fill_addr[OFFSET_W +: INDEX_W];
  assign fill_tag   = fill_addr[ADDR_WIDTH-1 -: TAG_W];
  assign unused_fill_offset = ^fill_addr[OFFSET_W-1:0];

  icache_tag_array #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .rd_index   (s1_index),
    .rd_valid   (arr_valid),
    .rd_tag     (arr_tag),
    .rd_lru     (arr_lru),
    .upd_en     (upd_en),
    .upd_index  (s1_index),
    .upd_way    (hit_way),
    .upd_inv    (upd_inv),
    .upd_lru    (upd_lru),
    .fill_en    (fill_vld),
    .fill_index (fill_index),
    .fill_way   (fill_way),
    .fill_tag   (fill_tag)
  );

  always_comb begin
    eff_valid = arr_valid;
    eff_tag   = arr_tag;
`ifdef ICACHE_TAG_FILL_BYPASS_EN
    if (fill_vld && (fill_index == s1_index)) begin
      eff_valid[fill_way] = 1'b1;
      eff_tag[fill_way]   = fill_tag;
    end
`endif
    way_match[0] = eff_valid[0] && (eff_tag[0] == s1_tag);
    way_match[1] = eff_valid[1] && (eff_tag[1] == s1_tag);
    hit     = |way_match;
    hit_way = !way_match[0];
    victim  = pick_victim(eff_valid, arr_lru);
  end

  always_comb begin
    upd_en  = 1'b0;
    upd_inv = 1'b0;
    upd_lru = 1'b0;
    if (s1_adv && hit) begin
      case (s1_req.opcode)
        OPC_READ: begin
          upd_en  = 1'b1;
          upd_lru = ~hit_way;
        end
        OPC_SNP_INV: begin
          upd_en  = 1'b1;
          upd_inv = 1'b1;
          upd_lru = hit_way;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_req <= '0;
    end else if (accept) begin
      s1_vld <= 1'b1;
      s1_req <= '{opcode: tag_req_opcode, txnid: tag_req_txnid, addr: tag_req_addr};
    end else if (s1_adv) begin
      s1_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else if (s1_adv) begin
      res_vld_q <= 1'b1;
      res_q     <= '{req: s1_req, hit: hit, way: hit ? hit_way : victim};
    end else if (res_rdy) begin
      res_vld_q <= 1'b0;
    end
  end

  assign res_vld    = res_vld_q;
  assign res_opcode = res_q.req.opcode;
  assign res_txnid  = res_q.req.txnid;
  assign res_addr   = res_q.req.addr;
  assign res_hit    = res_q.hit;
  assign res_way    = res_q.way;

endmodule

// File: tb/tb_icache_tag_lookup.sv
// Directed bench for icache_tag_lookup: vector table plus backpressure, same-cycle fill and reset sequences.
module tb_icache_tag_lookup;
  import icache_tag_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        tag_req_vld, tag_req_rdy;
  logic [6:0]  tag_req_opcode;
  logic [3:0]  tag_req_txnid;
  logic [31:0] tag_req_addr;
  logic        fill_vld, fill_way;
  logic [31:0] fill_addr;
  logic        res_vld, res_rdy, res_hit, res_way;
  logic [6:0]  res_opcode;
  logic [3:0]  res_txnid;
  logic [31:0] res_addr;

  always #5 clk = ~clk;

  icache_tag_lookup #(
    .ADDR_WIDTH   (32),
    .TXNID_WIDTH  (4),
    .OPCODE_WIDTH (7),
    .SETS         (64),
    .LINE_BYTES   (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tag_req_vld    (tag_req_vld),
    .tag_req_rdy    (tag_req_rdy),
    .tag_req_opcode (tag_req_opcode),
    .tag_req_txnid  (tag_req_txnid),
    .tag_req_addr   (tag_req_addr),
    .fill_vld       (fill_vld),
    .fill_addr      (fill_addr),
    .fill_way       (fill_way),
    .res_vld        (res_vld),
    .res_rdy        (res_rdy),
    .res_opcode     (res_opcode),
    .res_txnid      (res_txnid),
    .res_addr       (res_addr),
    .res_hit        (res_hit),
    .res_way        (res_way)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_fill;
    logic [6:0]  opc;
    logic [31:0] addr;
    logic        way;
    logic        exp_hit;
    logic        exp_way;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t vr(logic [6:0] o, logic [31:0] a, logic h, logic w);
    vec_t v;
    v.is_fill = 1'b0; v.opc = o; v.addr = a; v.way = 1'b0; v.exp_hit = h; v.exp_way = w;
    return v;
  endfunction

  function automatic vec_t vf(logic [31:0] a, logic w);
    vec_t v;
    v.is_fill = 1'b1; v.opc = '0; v.addr = a; v.way = w; v.exp_hit = 1'b0; v.exp_way = 1'b0;
    return v;
  endfunction

  task automatic do_fill(input logic [31:0] addr, input logic way);
    @(negedge clk);
    fill_vld = 1'b1; fill_addr = addr; fill_way = way;
    @(negedge clk);
    fill_vld = 1'b0;
  endtask

  // Single request with res_rdy high: checks 2-cycle latency and the carried fields.
  task automatic do_req(input logic [6:0] opc, input logic [31:0] addr, input logic [3:0] id,
                        input logic exp_hit, input logic exp_way, input string nm);
    int n;
    @(negedge clk);
    tag_req_vld = 1'b1; tag_req_opcode = opc; tag_req_addr = addr; tag_req_txnid = id;
    #1;
    n = 0;
    while (!tag_req_rdy && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, ".accept"}, 32'(n < 20), 32'd1);
    @(negedge clk);
    tag_req_vld = 1'b0;
    chk({nm, ".early_vld"}, res_vld, 1'b0);
    @(negedge clk);
    chk({nm, ".vld"}, res_vld, 1'b1);
    chk({nm, ".hit"}, res_hit, exp_hit);
    chk({nm, ".way"}, res_way, exp_way);
    chk({nm, ".txnid"}, res_txnid, id);
    chk({nm, ".addr"}, res_addr, addr);
    chk({nm, ".opcode"}, res_opcode, opc);
  endtask

  // Request whose S1 cycle coincides with a fill strobe.
  task automatic req_with_fill(input logic [6:0] opc, input logic [31:0] addr,
                               input logic [31:0] faddr, input logic fway,
                               input logic exp_hit, input logic exp_way, input string nm);
    @(negedge clk);
    tag_req_vld = 1'b1; tag_req_opcode = opc; tag_req_addr = addr; tag_req_txnid = 4'hA;
    #1;
    chk({nm, ".rdy"}, tag_req_rdy, 1'b1);
    @(negedge clk);
    tag_req_vld = 1'b0;
    fill_vld = 1'b1; fill_addr = faddr; fill_way = fway;
    @(negedge clk);
    fill_vld = 1'b0;
    chk({nm, ".vld"}, res_vld, 1'b1);
    chk({nm, ".hit"}, res_hit, exp_hit);
    chk({nm, ".way"}, res_way, exp_way);
  endtask

  logic [3:0] got_id [4];
  logic       got_hit [4];
  logic       got_way [4];
  int         got;

  task automatic collect(input int n, input int budget);
    got = 0;
    for (int k = 0; k < budget && got < n; k++) begin
      if (res_vld && got < 4) begin
        got_id[got] = res_txnid; got_hit[got] = res_hit; got_way[got] = res_way;
        got++;
      end
      @(negedge clk);
      tag_req_vld = 1'b0;
      #1;
    end
    chk("collect.count", got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  hold_id;
    logic [31:0] hold_addr;
    logic        exp_bp_hit;
    logic        exp_bp_way;

    reset = 1'b1; res_rdy = 1'b1;
    tag_req_vld = 1'b1; tag_req_opcode = OPC_READ; tag_req_txnid = '0; tag_req_addr = '0;
    fill_vld = 1'b0; fill_addr = '0; fill_way = 1'b0;
    #1;
    chk("reset.rdy", tag_req_rdy, 1'b0);
    chk("reset.res_vld", res_vld, 1'b0);
    chk("reset.res_hit", res_hit, 1'b0);
    chk("reset.res_addr", res_addr, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0; tag_req_vld = 1'b0;
    #1;
    chk("post_reset.rdy", tag_req_rdy, 1'b1);

    // Set 1: tags 0x1 (0x1040), 0x2 (0x2040), 0x3 (0x3040).
    vecs.push_back(vr(OPC_READ,     32'h0000_1040, 1'b0, 1'b0));
    vecs.push_back(vr(OPC_READ,     32'h0000_1040, 1'b0, 1'b0));
    vecs.push_back(vf(32'h0000_1040, 1'b0));
    vecs.push_back(vr(OPC_READ,     32'h0000_1040, 1'b1, 1'b0));
    vecs.push_back(vr(OPC_PREFETCH, 32'h0000_2040, 1'b0, 1'b1));
    vecs.push_back(vf(32'h0000_2040, 1'b1));
    vecs.push_back(vr(OPC_READ,     32'h0000_107F, 1'b1, 1'b0));
    vecs.push_back(vr(OPC_READ,     32'h0000_3040, 1'b0, 1'b1));
    vecs.push_back(vr(OPC_READ,     32'h0000_2040, 1'b1, 1'b1));
    vecs.push_back(vr(OPC_READ,     32'h0000_3040, 1'b0, 1'b0));
    vecs.push_back(vr(OPC_PREFETCH, 32'h0000_1040, 1'b1, 1'b0));
    vecs.push_back(vr(OPC_READ,     32'h0000_3040, 1'b0, 1'b0));
    vecs.push_back(vr(OPC_SNP_INV,  32'h0000_2040, 1'b1, 1'b1));
    vecs.push_back(vr(OPC_READ,     32'h0000_2040, 1'b0, 1'b1));
    vecs.push_back(vr(7'h05,        32'h0000_1040, 1'b1, 1'b0));
    vecs.push_back(vr(OPC_READ,     32'h0000_3040, 1'b0, 1'b1));
    vecs.push_back(vr(OPC_SNP_INV,  32'h0000_3040, 1'b0, 1'b1));
    vecs.push_back(vr(OPC_READ,     32'h0000_1080, 1'b0, 1'b0));
    vecs.push_back(vf(32'h0000_1080, 1'b1));
    vecs.push_back(vr(OPC_READ,     32'h0000_1080, 1'b1, 1'b1));
    vecs.push_back(vr(OPC_READ,     32'h0000_2080, 1'b0, 1'b0));
    vecs.push_back(vf(32'hFFFF_FFC0, 1'b0));
    vecs.push_back(vr(OPC_READ,     32'hFFFF_FFC0, 1'b1, 1'b0));
    vecs.push_back(vr(OPC_READ,     32'h7FFF_FFC0, 1'b0, 1'b1));

    foreach (vecs[i]) begin
      if (vecs[i].is_fill) do_fill(vecs[i].addr, vecs[i].way);
      else do_req(vecs[i].opc, vecs[i].addr, 4'(i), vecs[i].exp_hit, vecs[i].exp_way,
                  $sformatf("vec%0d", i));
    end

    // Backpressure: res_rdy low for 5 cycles with three requests offered.
    @(negedge clk);
    res_rdy = 1'b0;
    tag_req_vld = 1'b1; tag_req_opcode = OPC_PREFETCH; tag_req_addr = 32'h0000_1040; tag_req_txnid = 4'd1;
    @(negedge clk);
    tag_req_addr = 32'h0000_2040; tag_req_txnid = 4'd2;
    @(negedge clk);
    tag_req_addr = 32'h0000_1080; tag_req_txnid = 4'd3;
    #1;
    chk("bp.rdy_low", tag_req_rdy, 1'b0);
    chk("bp.res_vld", res_vld, 1'b1);
    hold_id = res_txnid; hold_addr = res_addr;
    chk("bp.first_id", hold_id, 4'd1);
    repeat (3) begin
      @(negedge clk); #1;
      chk("bp.hold_rdy", tag_req_rdy, 1'b0);
      chk("bp.hold_vld", res_vld, 1'b1);
      chk("bp.hold_id", res_txnid, hold_id);
      chk("bp.hold_addr", res_addr, hold_addr);
    end
    res_rdy = 1'b1;
    #1;
    chk("bp.release_rdy", tag_req_rdy, 1'b1);
    collect(3, 10);
    for (int k = 0; k < 3; k++) begin
      exp_bp_hit = (k != 1);
      exp_bp_way = (k != 0);
      chk($sformatf("bp.id%0d", k), got_id[k], 4'(k + 1));
      chk($sformatf("bp.hit%0d", k), got_hit[k], exp_bp_hit);
      chk($sformatf("bp.way%0d", k), got_way[k], exp_bp_way);
    end

    // Same-cycle fill and S1 READ of the same line (set 3, tag 5).
`ifdef ICACHE_TAG_FILL_BYPASS_EN
    req_with_fill(OPC_READ, 32'h0000_50C0, 32'h0000_50C0, 1'b1, 1'b1, 1'b1, "bypass");
`else
    req_with_fill(OPC_READ, 32'h0000_50C0, 32'h0000_50C0, 1'b1, 1'b0, 1'b0, "bypass");
`endif
    do_req(OPC_READ, 32'h0000_50C0, 4'd4, 1'b1, 1'b1, "after_fill");

    // Back-to-back to one set: the READ must observe the SNP_INV.
    @(negedge clk);
    tag_req_vld = 1'b1; tag_req_opcode = OPC_SNP_INV; tag_req_addr = 32'h0000_50C0; tag_req_txnid = 4'd5;
    @(negedge clk);
    tag_req_opcode = OPC_READ; tag_req_txnid = 4'd6;
    collect(2, 10);
    chk("b2b.id0", got_id[0], 4'd5);
    chk("b2b.hit0", got_hit[0], 1'b1);
    chk("b2b.way0", got_way[0], 1'b1);
    chk("b2b.id1", got_id[1], 4'd6);
    chk("b2b.hit1", got_hit[1], 1'b0);
    chk("b2b.way1", got_way[1], 1'b0);

    // Fill overrides a same-cycle SNP_INV on the same set (set 4).
    do_fill(32'h0000_5100, 1'b0);
    do_fill(32'h0000_6100, 1'b1);
    req_with_fill(OPC_SNP_INV, 32'h0000_5100, 32'h0000_5100, 1'b0, 1'b1, 1'b0, "fill_wins");
    do_req(OPC_READ, 32'h0000_7100, 4'd7, 1'b0, 1'b1, "fill_wins_lru");
    do_req(OPC_READ, 32'h0000_5100, 4'd8, 1'b1, 1'b0, "fill_wins_valid");

    // Asynchronous reset with a request in flight.
    @(negedge clk);
    tag_req_vld = 1'b1; tag_req_opcode = OPC_READ; tag_req_addr = 32'h0000_1040; tag_req_txnid = 4'd9;
    @(negedge clk);
    tag_req_vld = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_reset.res_vld", res_vld, 1'b0);
    chk("mid_reset.rdy", tag_req_rdy, 1'b0);
    chk("mid_reset.txnid", res_txnid, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_reset.dropped", res_vld, 1'b0);
    end
    do_req(OPC_READ, 32'h0000_1040, 4'd10, 1'b0, 1'b0, "array_cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
